nr_divider: RTL and testbench
=============================

Name: nr_divider

Overview:
Parametrised, iterative, unsigned non-restoring divider. It is the registered, sequenced successor of the combinational add/sub + mux datapath: the same signed add/sub step on a WIDTH+2 partial remainder, now driven by an FSM and iteration counter. One quotient bit is produced per clock, followed by a final remainder-correction cycle. It sits beside the existing arithmetic datapath blocks and is fed by a start/done handshake from the controlling FSM.

Parameters:
WIDTH, 32, dividend/divisor/quotient/remainder width in bits (legal range 4..64).
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
clock  input  1  rising-edge clock
reset_n  input  1  asynchronous reset, active low
start  input  1  request; sampled only in IDLE or in the DONE cycle
dividend  input  WIDTH  unsigned dividend; sampled on the accepting edge
divisor  input  WIDTH  unsigned divisor; sampled on the accepting edge
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; results valid from this cycle on
quotient  output  WIDTH  result quotient; held until the next completion
remainder  output  WIDTH  result remainder; held until the next completion
div_by_zero  output  1  set with done when divisor==0; held like the results

Behaviour:
- Reset: async assert (reset_n=0) forces state IDLE; busy, done, div_by_zero, quotient, remainder, counter and internal registers all go to 0. Release is synchronous to clock. Reset mid-division aborts the operation, with no done pulse.
- States: IDLE, RUN, CORR, DONE.
- IDLE, start=1 at edge k, divisor!=0:
  - Load P (signed, WIDTH+2) = 0, Q = dividend, D = zero-extended divisor, counter = WIDTH.
  - Go to RUN; busy=1.
- IDLE, start=1 at edge k, divisor==0:
  - Go directly to DONE.
  - quotient = all ones, remainder = dividend, div_by_zero=1, done=1 after edge k (latency 1).
- RUN, each edge:
  - Shift {P,Q} left by 1; S is the shifted P.
  - If the old P sign bit is 0, P = S − D; else P = S + D.
  - The new Q LSB = ~sign(new P). Decrement counter.
  - When the counter reaches 0 after this edge, go to CORR.
  - RUN lasts exactly WIDTH edges (k+1..k+WIDTH).
- CORR, edge k+WIDTH+1:
  - If P is negative, P = P + D.
  - quotient = Q, remainder = P[WIDTH-1:0], div_by_zero=0.
  - done=1, busy=0; go to DONE.
- DONE (one cycle, done=1):
  - start=1 is accepted exactly as from IDLE (back-to-back; the done pulse still lasts only one cycle).
  - Otherwise go to IDLE.
- Latency: done is high in the cycle following edge k+WIDTH+1, i.e. WIDTH+1 cycles after acceptance. Throughput is one result per WIDTH+1 cycles.
- start while busy (RUN/CORR) is ignored; operand changes during RUN have no effect.
- Arithmetic: P carries 2 guard bits (WIDTH+2). No overflow is possible for unsigned operands; all add/sub is modulo 2^(WIDTH+2). The final remainder is always in [0, divisor−1].
- Outputs are registered; no combinational path from any input to any output.

Test Plan:
- WIDTH=32, dividend=100, divisor=7, start pulse -> busy for 33 cycles; done pulse 33 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0; dividend=5, divisor=9 -> quotient=0, remainder=5.
- divisor=0, dividend=0x1234 -> done one cycle after acceptance; quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1, busy never high.
- start with 100/7, then start with 50/5 held high during RUN -> second request ignored; result 14 r 2. Re-issue 50/5 during the DONE cycle -> accepted back-to-back; quotient=10, remainder=0.
- reset_n low at RUN cycle 10 of 100/7 -> all outputs 0 immediately (async, mid-clock); no done; after release a fresh 100/7 completes normally.
- WIDTH=8 instance: 200/13 -> quotient=15, remainder=5, done 9 cycles after acceptance; random 1000-vector sweep against a reference model -> exact match.

Source files
------------

// File: rtl/nr_divider.sv
// -----------------------------------------------------------------------------
// nr_divider
//   Iterative unsigned non-restoring divider. It produces one quotient bit per
//   clock over WIDTH RUN cycles, followed by one remainder-correction cycle.
//   The partial remainder P is kept signed on WIDTH+2 bits, so the add/sub
//   step can never overflow.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        request; accepted only in IDLE or in the DONE cycle
//   dividend     unsigned dividend, sampled on the accepting edge
//   divisor      unsigned divisor, sampled on the accepting edge
//   busy         high while a division is in progress
//   done         one-cycle completion pulse
//   quotient     result quotient, held until the next completion
//   remainder    result remainder, held until the next completion
//   div_by_zero  set together with done when divisor was 0
// -----------------------------------------------------------------------------
module nr_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int PW = WIDTH + 2;

    typedef enum logic [1:0] {IDLE, RUN, CORR, DONE} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    p, p_nxt;          // partial remainder, two's complement
    logic [PW-1:0]    d, d_nxt;          // zero-extended divisor
    logic [WIDTH-1:0] q, q_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             busy_nxt, done_nxt, dbz_nxt;
    logic [WIDTH-1:0] quot_nxt, rem_nxt;
    logic [PW-1:0]    shifted, step;

    // One non-restoring step: the sign of the old P selects add or subtract.
    always_comb begin
        shifted = {p[PW-2:0], q[WIDTH-1]};
        step    = p[PW-1] ? shifted + d : shifted - d;
    end

    always_comb begin
        state_nxt = state;
        p_nxt     = p;
        d_nxt     = d;
        q_nxt     = q;
        cnt_nxt   = cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        dbz_nxt   = div_by_zero;
        quot_nxt  = quotient;
        rem_nxt   = remainder;

        case (state)
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        // Division by zero short-circuits straight to DONE.
                        state_nxt = DONE;
                        quot_nxt  = '1;
                        rem_nxt   = dividend;
                        dbz_nxt   = 1'b1;
                        done_nxt  = 1'b1;
                        busy_nxt  = 1'b0;
                    end else begin
                        state_nxt = RUN;
                        p_nxt     = '0;
                        q_nxt     = dividend;
                        d_nxt     = {2'b00, divisor};
                        cnt_nxt   = CNT_W'(WIDTH);
                        busy_nxt  = 1'b1;
                    end
                end
            end

            RUN: begin
                p_nxt   = step;
                q_nxt   = {q[WIDTH-2:0], ~step[PW-1]};
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1))
                    state_nxt = CORR;
            end

            CORR: begin
                // A negative final P is one divisor short; add it back.
                p_nxt     = p[PW-1] ? p + d : p;
                quot_nxt  = q;
                rem_nxt   = p_nxt[WIDTH-1:0];
                dbz_nxt   = 1'b0;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = DONE;
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            p           <= '0;
            d           <= '0;
            q           <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            state       <= state_nxt;
            p           <= p_nxt;
            d           <= d_nxt;
            q           <= q_nxt;
            cnt         <= cnt_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            div_by_zero <= dbz_nxt;
            quotient    <= quot_nxt;
            remainder   <= rem_nxt;
        end
    end

endmodule

// File: tb/tb_nr_divider.sv
// -----------------------------------------------------------------------------
// tb_nr_divider
//   Directed bench for nr_divider using a WIDTH=32 and a WIDTH=8 instance on a
//   shared clock and reset. Latency is counted in clock edges after the
//   accepting edge: a normal division completes WIDTH+1 edges later, and a
//   divide-by-zero completes on the accepting edge itself.
// -----------------------------------------------------------------------------
module tb_nr_divider;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;

    logic        start32 = 1'b0;
    logic [31:0] dvd32 = '0, dvs32 = '0;
    logic        busy32, done32, dbz32;
    logic [31:0] quo32, rem32;

    logic        start8 = 1'b0;
    logic [7:0]  dvd8 = '0, dvs8 = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  quo8, rem8;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    nr_divider #(.WIDTH(32)) u_div32 (
        .clock(clock), .reset_n(reset_n), .start(start32),
        .dividend(dvd32), .divisor(dvs32), .busy(busy32), .done(done32),
        .quotient(quo32), .remainder(rem32), .div_by_zero(dbz32)
    );

    nr_divider #(.WIDTH(8)) u_div8 (
        .clock(clock), .reset_n(reset_n), .start(start8),
        .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
        .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge so that it is accepted on the following posedge.
    task automatic issue(input bit sel8, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        if (sel8) begin start8 = 1'b1; dvd8 = a[7:0]; dvs8 = b[7:0]; end
        else      begin start32 = 1'b1; dvd32 = a; dvs32 = b; end
        @(posedge clock);
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
    endtask

    // Count negedges until done is seen. Returns the edge count after acceptance
    // and the number of sampled cycles in which busy was high.
    task automatic wait_done(input bit sel8, output int lat, output int bcnt);
        bit found;
        found = 1'b0;
        lat   = -1;
        bcnt  = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (sel8 ? busy8 : busy32) bcnt++;
            if (sel8 ? done8 : done32) begin
                lat   = i;
                found = 1'b1;
                break;
            end
        end
        chk("done_seen", 64'(found), 64'd1);
    endtask

    task automatic div32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input bit ez);
        int lat, bc;
        issue(1'b0, a, b);
        wait_done(1'b0, lat, bc);
        chk({tag, "_q"},   64'(quo32), 64'(eq));
        chk({tag, "_r"},   64'(rem32), 64'(er));
        chk({tag, "_dbz"}, 64'(dbz32), 64'(ez));
        chk({tag, "_lat"}, 64'(lat), ez ? 64'd0 : 64'd33);
        chk({tag, "_busy"}, 64'(bc), ez ? 64'd0 : 64'd33);
    endtask

    initial begin
        int lat, bc, seen;
        logic [7:0] a8, b8, eq8, er8;

        // Reset state
        #12;
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'(done32), 64'd0);
        chk("rst_q",    64'(quo32),  64'd0);
        chk("rst_r",    64'(rem32),  64'd0);
        chk("rst_dbz",  64'(dbz32),  64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Basic divisions
        div32("d100_7",   32'd100,        32'd7, 32'd14,         32'd2, 1'b0);
        div32("dmax_1",   32'hFFFF_FFFF,  32'd1, 32'hFFFF_FFFF,  32'd0, 1'b0);
        div32("d5_9",     32'd5,          32'd9, 32'd0,          32'd5, 1'b0);
        div32("dmax_max", 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,  32'd0, 1'b0);
        div32("dbig",     32'hDEAD_BEEF,  32'h0001_0000, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0);
        div32("dzero",    32'h1234,       32'd0, 32'hFFFF_FFFF,  32'h1234, 1'b1);
        // A normal result after divide-by-zero must clear the flag
        div32("d49_7",    32'd49,         32'd7, 32'd7,          32'd0, 1'b0);

        // Start held high with new operands during RUN is ignored
        issue(1'b0, 32'd100, 32'd7);
        @(negedge clock);
        start32 = 1'b1; dvd32 = 32'd50; dvs32 = 32'd5;
        repeat (9) @(negedge clock);
        start32 = 1'b0;
        wait_done(1'b0, lat, bc);
        chk("ign_lat", 64'(lat + 10), 64'd33);
        chk("ign_q",   64'(quo32), 64'd14);
        chk("ign_r",   64'(rem32), 64'd2);

        // Back-to-back: request during the DONE cycle is accepted on the next edge
        start32 = 1'b1; dvd32 = 32'd50; dvs32 = 32'd5;
        @(posedge clock);
        #1 start32 = 1'b0;
        wait_done(1'b0, lat, bc);
        chk("b2b_lat", 64'(lat), 64'd33);
        chk("b2b_q",   64'(quo32), 64'd10);
        chk("b2b_r",   64'(rem32), 64'd0);

        // Asynchronous reset in the middle of RUN
        issue(1'b0, 32'd100, 32'd7);
        repeat (10) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy32), 64'd0);
        chk("arst_done", 64'(done32), 64'd0);
        chk("arst_q",    64'(quo32),  64'd0);
        chk("arst_r",    64'(rem32),  64'd0);
        chk("arst_dbz",  64'(dbz32),  64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done32 || busy32) seen++;
        end
        chk("arst_quiet", 64'(seen), 64'd0);
        div32("post_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // WIDTH=8 instance
        issue(1'b1, 32'd200, 32'd13);
        wait_done(1'b1, lat, bc);
        chk("w8_lat", 64'(lat),  64'd9);
        chk("w8_q",   64'(quo8), 64'd15);
        chk("w8_r",   64'(rem8), 64'd5);
        chk("w8_dbz", 64'(dbz8), 64'd0);

        // Random sweep on the 8-bit instance against the built-in operators
        for (int i = 0; i < 1000; i++) begin
            a8 = 8'($urandom_range(0, 255));
            b8 = (i % 50 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            if (b8 == 8'd0) begin eq8 = 8'hFF; er8 = a8; end
            else            begin eq8 = a8 / b8; er8 = a8 % b8; end
            issue(1'b1, {24'd0, a8}, {24'd0, b8});
            wait_done(1'b1, lat, bc);
            chk("w8_rand", {31'd0, dbz8, 16'd0, quo8, rem8},
                           {31'd0, (b8 == 8'd0), 16'd0, eq8, er8});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
